// File: rtl/s2p_pkg.sv
// s2p_pkg: shared types and elaboration helpers for the s2p_deser deserialiser.
//   s2p_state_e : FSM state encoding (IDLE, SHIFT, PAR)
//   s2p_beats   : beats per word, DW / LANES
//   s2p_cnt_w   : beat counter width, $clog2(BEATS) with a minimum of 1
//   s2p_cfg_ok  : parameter legality check consumed at elaboration by the top
package s2p_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } s2p_state_e;

    function automatic int unsigned s2p_beats(input int unsigned dw, input int unsigned lanes);
        return dw / lanes;
    endfunction

    function automatic int unsigned s2p_cnt_w(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    // Lane count must be a power of two up to 8 and must divide the word width.
    function automatic bit s2p_cfg_ok(input int unsigned dw, input int unsigned lanes);
        return ((lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8)) &&
               (dw >= lanes) && ((dw % lanes) == 0);
    endfunction

endpackage

// File: rtl/s2p_deser_if.sv
// s2p_deser_if: serial input and word output bundle of the s2p_deser deserialiser.
//   wra_n      : active-low write strobe         (master -> slave)
//   din        : LANES-bit serial beat           (master -> slave)
//   dout_ready : consumer accepts the held word  (master -> slave)
//   ovf_clr    : clears the sticky overflow flag (master -> slave)
//   dout       : DW-bit assembled word           (slave -> master)
//   dout_valid : dout holds a word               (slave -> master)
//   dout_perr  : parity error for the held word  (slave -> master)
//   ovf        : sticky overflow flag            (slave -> master)
//   abort      : one-cycle partial-word discard  (slave -> master)
interface s2p_deser_if #(
    parameter int unsigned DW    = 8,
    parameter int unsigned LANES = 1
) ();

    logic             wra_n;
    logic [LANES-1:0] din;
    logic             dout_ready;
    logic             ovf_clr;
    logic [DW-1:0]    dout;
    logic             dout_valid;
    logic             dout_perr;
    logic             ovf;
    logic             abort;

    modport master (
        output wra_n, din, dout_ready, ovf_clr,
        input  dout, dout_valid, dout_perr, ovf, abort
    );

    modport slave (
        input  wra_n, din, dout_ready, ovf_clr,
        output dout, dout_valid, dout_perr, ovf, abort
    );

endinterface

// File: rtl/s2p_out_reg.sv
// s2p_out_reg: one-word holding register on a valid/ready port with sticky overflow.
//   clk, rstn : clock, synchronous active-low reset
//   load_i    : a completed word is offered this cycle
//   word_i    : the completed word
//   perr_i    : parity error flag travelling with word_i
//   ready_i   : consumer accepts the held word
//   clr_i     : clears the overflow flag (a same-cycle overflow wins)
//   dout_o    : held word
//   valid_o   : dout_o holds a word
//   perr_o    : parity error flag of the held word
//   ovf_o     : sticky overflow flag
module s2p_out_reg #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load_i,
    input  logic [DW-1:0] word_i,
    input  logic          perr_i,
    input  logic          ready_i,
    input  logic          clr_i,
    output logic [DW-1:0] dout_o,
    output logic          valid_o,
    output logic          perr_o,
    output logic          ovf_o
);

    logic [DW-1:0] dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          perr_q, perr_d;
    logic          ovf_q, ovf_d;
    logic          ovf_set_c;

    // A new word is accepted only if the slot is empty or drains in the same cycle.
    always_comb begin
        dout_d    = dout_q;
        valid_d   = valid_q;
        perr_d    = perr_q;
        ovf_set_c = 1'b0;

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        if (load_i) begin
            if (!valid_q || ready_i) begin
                dout_d  = word_i;
                perr_d  = perr_i;
                valid_d = 1'b1;
            end else begin
                ovf_set_c = 1'b1;
            end
        end

        ovf_d = ovf_set_c | (ovf_q & ~clr_i);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dout_o  = dout_q;
    assign valid_o = valid_q;
    assign perr_o  = perr_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/s2p_deser.sv
// s2p_deser: parametrised serial-to-parallel deserialiser (LANES bits per beat into DW-bit words).
//   clk  : single rising-edge clock
//   rstn : synchronous active-low reset
//   bus  : s2p_deser_if.slave -- wra_n/din/dout_ready/ovf_clr in,
//          dout/dout_valid/dout_perr/ovf/abort out
// Optional feature: define S2P_DESER_PARITY_EN to expect one even-parity beat on din[0]
// after each word; mismatches are flagged on dout_perr. Without it dout_perr is constant 0.
module s2p_deser
    import s2p_pkg::*;
#(
    parameter int unsigned DW        = 8,
    parameter int unsigned LANES     = 1,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic      clk,
    input  logic      rstn,
    s2p_deser_if.slave bus
);

    localparam int unsigned BEATS  = s2p_beats(DW, LANES);
    localparam int unsigned CW     = s2p_cnt_w(BEATS);
    localparam bit          CFG_OK = s2p_cfg_ok(DW, LANES);

    if (!CFG_OK) begin : g_bad_cfg
        $error("s2p_deser: LANES must be 1, 2, 4 or 8 and divide DW");
    end

    s2p_state_e    state_q;
    logic [CW-1:0] beat_cnt_q;
    logic [DW-1:0] sr_q;
    logic          load_q;
    logic          abort_q;
    logic          word_perr;
    logic [DW-1:0] sr_shift_c;
    logic          last_beat_c;

    // Both orders keep din[LANES-1] as the beat MSB; only the insertion end differs.
    if (MSB_FIRST) begin : g_msb
        assign sr_shift_c = (sr_q << LANES) | DW'(bus.din);
    end else begin : g_lsb
        assign sr_shift_c = (sr_q >> LANES) | (DW'(bus.din) << (DW - LANES));
    end

    assign last_beat_c = (beat_cnt_q == CW'(BEATS - 1));

`ifdef S2P_DESER_PARITY_EN
    logic perr_q;
    assign word_perr = perr_q;
`else
    assign word_perr = 1'b0;
`endif

    // Beat capture FSM; load_q marks the cycle in which sr_q holds a finished word.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            sr_q       <= '0;
            load_q     <= 1'b0;
            abort_q    <= 1'b0;
`ifdef S2P_DESER_PARITY_EN
            perr_q     <= 1'b0;
`endif
        end else begin
            load_q  <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                IDLE, SHIFT: begin
                    if (!bus.wra_n) begin
                        sr_q <= sr_shift_c;
                        if (last_beat_c) begin
                            beat_cnt_q <= '0;
`ifdef S2P_DESER_PARITY_EN
                            state_q    <= PAR;
`else
                            state_q    <= SHIFT;
                            load_q     <= 1'b1;
`endif
                        end else begin
                            beat_cnt_q <= beat_cnt_q + CW'(1);
                            state_q    <= SHIFT;
                        end
                    end else begin
                        // Only a started word counts as discarded; a word boundary gap is silent.
                        abort_q    <= (beat_cnt_q != '0);
                        beat_cnt_q <= '0;
                        state_q    <= IDLE;
                    end
                end
`ifdef S2P_DESER_PARITY_EN
                PAR: begin
                    beat_cnt_q <= '0;
                    if (!bus.wra_n) begin
                        load_q  <= 1'b1;
                        perr_q  <= (^sr_q) ^ bus.din[0];
                        state_q <= SHIFT;
                    end else begin
                        abort_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
`endif
                default: begin
                    beat_cnt_q <= '0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    s2p_out_reg #(
        .DW (DW)
    ) u_out_reg (
        .clk     (clk),
        .rstn    (rstn),
        .load_i  (load_q),
        .word_i  (sr_q),
        .perr_i  (word_perr),
        .ready_i (bus.dout_ready),
        .clr_i   (bus.ovf_clr),
        .dout_o  (bus.dout),
        .valid_o (bus.dout_valid),
        .perr_o  (bus.dout_perr),
        .ovf_o   (bus.ovf)
    );

    assign bus.abort = abort_q;

endmodule

// File: tb/tb_s2p_deser.sv
// tb_s2p_deser: directed and random stimulus against a beat-counting reference model
// for three s2p_deser configurations (8x1 MSB-first, 8x1 LSB-first, 16x4 MSB-first).
module tb_s2p_deser;

    // Reference model state: words are built arithmetically from beat positions.
    typedef struct packed {
        logic [4:0]  nb;
        logic [15:0] acc;
        logic        par_ph;
        logic        done;
        logic [15:0] dword;
        logic        dperr;
        logic        valid;
        logic [15:0] dout;
        logic        perr;
        logic        ovf;
        logic        abort;
    } mdl_t;

    logic       clk;
    logic       rstn;
    logic       wra8, din8, rdy8, clr8;
    logic       wra16, rdy16, clr16;
    logic [3:0] din16;

    int checks = 0;
    int errors = 0;
    mdl_t ma, mb, mc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    s2p_deser_if #(.DW(8),  .LANES(1)) if_a ();
    s2p_deser_if #(.DW(8),  .LANES(1)) if_b ();
    s2p_deser_if #(.DW(16), .LANES(4)) if_c ();

    assign if_a.wra_n = wra8;  assign if_a.din = din8;  assign if_a.dout_ready = rdy8;  assign if_a.ovf_clr = clr8;
    assign if_b.wra_n = wra8;  assign if_b.din = din8;  assign if_b.dout_ready = rdy8;  assign if_b.ovf_clr = clr8;
    assign if_c.wra_n = wra16; assign if_c.din = din16; assign if_c.dout_ready = rdy16; assign if_c.ovf_clr = clr16;

    s2p_deser #(.DW(8),  .LANES(1), .MSB_FIRST(1'b1)) u_a (.clk(clk), .rstn(rstn), .bus(if_a.slave));
    s2p_deser #(.DW(8),  .LANES(1), .MSB_FIRST(1'b0)) u_b (.clk(clk), .rstn(rstn), .bus(if_b.slave));
    s2p_deser #(.DW(16), .LANES(4), .MSB_FIRST(1'b1)) u_c (.clk(clk), .rstn(rstn), .bus(if_c.slave));

    // One clock edge of the specified behaviour, given the inputs present at that edge.
    function automatic mdl_t mdl_edge(input mdl_t m, input int beats, input int lanes, input bit msb,
                                      input logic rst_n, input logic wr_n, input logic [3:0] d,
                                      input logic rdy, input logic clr);
        mdl_t n;
        int dw;
        logic [15:0] mask;
        logic ovf_set;
        n = m;
        dw = beats * lanes;
        mask = (dw == 16) ? 16'hFFFF : 16'((32'd1 << dw) - 1);
        ovf_set = 1'b0;
        if (!rst_n) begin
            n = '0;
            return n;
        end
        if (m.valid && rdy) n.valid = 1'b0;
        if (m.done) begin
            if (!m.valid || rdy) begin
                n.dout  = m.dword;
                n.perr  = m.dperr;
                n.valid = 1'b1;
            end else begin
                ovf_set = 1'b1;
            end
        end
        n.ovf = ovf_set ? 1'b1 : (clr ? 1'b0 : m.ovf);
        n.abort = 1'b0;
        n.done  = 1'b0;
        if (m.par_ph) begin
            if (!wr_n) begin
                n.done  = 1'b1;
                n.dword = m.acc;
                n.dperr = (^m.acc) ^ d[0];
            end else begin
                n.abort = 1'b1;
            end
            n.par_ph = 1'b0;
            n.acc    = '0;
            n.nb     = '0;
        end else if (!wr_n) begin
            if (msb) n.acc = ((m.acc << lanes) | 16'(d)) & mask;
            else     n.acc = m.acc | (16'(d) << (lanes * int'(m.nb)));
            n.nb = m.nb + 5'd1;
            if (int'(n.nb) == beats) begin
                n.nb = '0;
`ifdef S2P_DESER_PARITY_EN
                n.par_ph = 1'b1;
`else
                n.done  = 1'b1;
                n.dword = n.acc;
                n.dperr = 1'b0;
                n.acc   = '0;
`endif
            end
        end else if (m.nb != 0) begin
            n.abort = 1'b1;
            n.nb    = '0;
            n.acc   = '0;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_inst(input string n, input logic v, input logic [15:0] d, input logic p,
                              input logic o, input logic a, input mdl_t m);
        chk({n, "_valid"}, 16'(v), 16'(m.valid));
        chk({n, "_ovf"},   16'(o), 16'(m.ovf));
        chk({n, "_abort"}, 16'(a), 16'(m.abort));
        if (m.valid) begin
            chk({n, "_dout"}, d, m.dout);
            chk({n, "_perr"}, 16'(p), 16'(m.perr));
        end
    endtask

    task automatic tick();
        ma = mdl_edge(ma, 8, 1, 1'b1, rstn, wra8,  4'(din8), rdy8,  clr8);
        mb = mdl_edge(mb, 8, 1, 1'b0, rstn, wra8,  4'(din8), rdy8,  clr8);
        mc = mdl_edge(mc, 4, 4, 1'b1, rstn, wra16, din16,    rdy16, clr16);
        @(posedge clk);
        #1;
        check_inst("a", if_a.dout_valid, 16'(if_a.dout), if_a.dout_perr, if_a.ovf, if_a.abort, ma);
        check_inst("b", if_b.dout_valid, 16'(if_b.dout), if_b.dout_perr, if_b.ovf, if_b.abort, mb);
        check_inst("c", if_c.dout_valid, if_c.dout,      if_c.dout_perr, if_c.ovf, if_c.abort, mc);
    endtask

    // Bits go out s[7] first; leaves wra8 low so words can run back to back.
    task automatic send8(input logic [7:0] s, input bit bad_par);
        for (int i = 0; i < 8; i++) begin
            wra8 = 1'b0;
            din8 = s[7-i];
            tick();
        end
`ifdef S2P_DESER_PARITY_EN
        wra8 = 1'b0;
        din8 = (^s) ^ bad_par;
        tick();
`else
        if (bad_par) din8 = 1'b0;
`endif
    endtask

    task automatic send16(input logic [15:0] w);
        for (int i = 0; i < 4; i++) begin
            wra16 = 1'b0;
            din16 = w[15-4*i -: 4];
            tick();
        end
`ifdef S2P_DESER_PARITY_EN
        wra16 = 1'b0;
        din16 = {3'b000, ^w};
        tick();
`endif
    endtask

    initial begin
        ma = '0; mb = '0; mc = '0;
        rstn = 1'b0;
        wra8 = 1'b1; din8 = 1'b0; rdy8 = 1'b1; clr8 = 1'b0;
        wra16 = 1'b1; din16 = 4'h0; rdy16 = 1'b1; clr16 = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_a_dout", 16'(if_a.dout), 16'h0);
        chk("rst_c_dout", if_c.dout, 16'h0);
        rstn = 1'b1;
        tick();

        // 0xA5 on both bit orders, then 0xC0 which the LSB-first unit sees as 0x03
        send8(8'hA5, 1'b0);
        wra8 = 1'b1;
        tick();
        chk("a5_a_dout", 16'(if_a.dout), 16'h00A5);
        chk("a5_b_dout", 16'(if_b.dout), 16'h00A5);
        chk("a5_valid",  16'(if_a.dout_valid), 16'h1);
        tick();
        chk("a5_valid_drop", 16'(if_a.dout_valid), 16'h0);
        send8(8'hC0, 1'b0);
        wra8 = 1'b1;
        tick();
        chk("c0_a_dout", 16'(if_a.dout), 16'h00C0);
        chk("c0_b_dout", 16'(if_b.dout), 16'h0003);
        tick();

        // Two 0x1234 words on 4 lanes with no gap
        send16(16'h1234);
        send16(16'h1234);
        wra16 = 1'b1;
        tick();
        chk("w16_dout", if_c.dout, 16'h1234);
        tick();

        // Overflow with the consumer stalled
        rdy8 = 1'b0;
        send8(8'h11, 1'b0);
        send8(8'h22, 1'b0);
        wra8 = 1'b1;
        tick();
        chk("ovf_set",  16'(if_a.ovf), 16'h1);
        chk("ovf_hold", 16'(if_a.dout), 16'h0011);
        clr8 = 1'b1;
        tick();
        clr8 = 1'b0;
        chk("ovf_clr", 16'(if_a.ovf), 16'h0);
        chk("ovf_still_valid", 16'(if_a.dout_valid), 16'h1);
        rdy8 = 1'b1;
        tick();
        chk("ovf_xfer", 16'(if_a.dout_valid), 16'h0);

        // Abort after 5 beats, then a clean 0xFF
        for (int i = 0; i < 5; i++) begin
            wra8 = 1'b0; din8 = 1'b1; tick();
        end
        wra8 = 1'b1;
        tick();
        chk("abort_pulse", 16'(if_a.abort), 16'h1);
        tick();
        chk("abort_end", 16'(if_a.abort), 16'h0);
        chk("abort_noword", 16'(if_a.dout_valid), 16'h0);
        send8(8'hFF, 1'b0);
        wra8 = 1'b1;
        tick();
        chk("ff_dout", 16'(if_a.dout), 16'h00FF);
        tick();

        // Reset mid-word with a word held: everything clears, no abort
        rdy8 = 1'b0;
        send8(8'h3C, 1'b0);
        for (int i = 0; i < 4; i++) begin
            wra8 = 1'b0; din8 = 1'b1; tick();
        end
        rstn = 1'b0;
        wra8 = 1'b1;
        rdy8 = 1'b1;
        tick();
        rstn = 1'b1;
        tick();
        chk("mrst_valid", 16'(if_a.dout_valid), 16'h0);
        chk("mrst_dout",  16'(if_a.dout), 16'h0);
        chk("mrst_abort", 16'(if_a.abort), 16'h0);
        chk("mrst_ovf",   16'(if_a.ovf), 16'h0);

`ifdef S2P_DESER_PARITY_EN
        // Good and bad parity beats on 0xA5
        send8(8'hA5, 1'b0);
        wra8 = 1'b1;
        tick();
        chk("par_ok_perr", 16'(if_a.dout_perr), 16'h0);
        tick();
        send8(8'hA5, 1'b1);
        wra8 = 1'b1;
        tick();
        chk("par_bad_dout", 16'(if_a.dout), 16'h00A5);
        chk("par_bad_perr", 16'(if_a.dout_perr), 16'h1);
        tick();
`endif

        // Random traffic: gaps, aborts, stalls and clears, all checked by the model
        for (int i = 0; i < 600; i++) begin
            wra8  = ($urandom_range(0, 9) == 0);
            din8  = 1'($urandom);
            rdy8  = ($urandom_range(0, 3) != 0);
            clr8  = ($urandom_range(0, 15) == 0);
            wra16 = ($urandom_range(0, 9) == 0);
            din16 = 4'($urandom);
            rdy16 = ($urandom_range(0, 2) != 0);
            clr16 = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
